// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RISC-V core, plus the opcode (ImmSrc) and
// ALU (ALUControl) decoders that steer the shared datapath.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal_op
);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpIAlu = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecuteR, StExecuteI, StAluWb, StBeq, StJal
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       branch, pc_update, state_valid;
  logic [1:0] imm_dec;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = StFetch;
    state_valid = 1'b1;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    illegal_op  = 1'b0;
    alu_op      = 2'b00;
    branch      = 1'b0;
    pc_update   = 1'b0;
    case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        // ALU forms OldPC + imm here so BEQ/JAL find the target in ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecuteR;
          OpIAlu:     state_d = StExecuteI;
          OpBeq:      state_d = StBeq;
          OpJal:      state_d = StJal;
          default:    illegal_op = 1'b1;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc  = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecuteR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = StAluWb;
      end
      StExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: RegWrite = 1'b1;
      StBeq: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      StJal: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      default: state_valid = 1'b0;
    endcase
  end

  // Zero reaches only PCWrite.
  assign PCWrite = pc_update | (branch & Zero);

  always_comb begin
    imm_dec = 2'b00;
    case (op)
      OpSw:    imm_dec = 2'b01;
      OpBeq:   imm_dec = 2'b10;
      OpJal:   imm_dec = 2'b11;
      default: imm_dec = 2'b00;
    endcase
  end

  assign ImmSrc = state_valid ? imm_dec : 2'b00;

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver queues the hand-computed
// output vector for each cycle, a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic       clk, rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [16:0] e;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  logic [16:0] actual;
  assign actual = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, ImmSrc, RegWrite, illegal_op};

  // Field order: pcw adr mw irw rs sa sb alu imm rw ill
  function automatic logic [16:0] ex(logic pcw, logic adr, logic mw, logic irw,
                                     logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                     logic [2:0] alu, logic [1:0] imm, logic rw, logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
  endfunction

  function automatic logic [16:0] ex_fetch(logic [1:0] imm);
    return ex(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0);
  endfunction

  function automatic logic [16:0] ex_decode(logic [1:0] imm, logic ill);
    return ex(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, ill);
  endfunction

  function automatic logic [16:0] ex_aluwb(logic [1:0] imm);
    return ex(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 0);
  endfunction

  // One cycle: apply inputs, queue the expected outputs, advance to just past the edge.
  task automatic step(input string nm, input logic r, input logic [6:0] o,
                      input logic [2:0] f3, input logic f7, input logic z,
                      input logic [16:0] e);
    exp_t it;
    rst = r; op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    it.nm = nm;
    it.e  = e;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t it;
      it = q.pop_front();
      tests++;
      if (actual !== it.e) begin
        fails++;
        $display("FAIL %s: got %b expected %b (pcw adr mw irw rs sa sb alu imm rw ill)",
                 it.nm, actual, it.e);
      end
    end
  end

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  initial begin
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    step("reset_fetch", 1, LW, 3'b010, 0, 0, ex_fetch(2'b00));

    // lw: 5 cycles
    step("lw_fetch",  0, LW, 3'b010, 0, 0, ex_fetch(2'b00));
    step("lw_decode", 0, LW, 3'b010, 0, 0, ex_decode(2'b00, 0));
    step("lw_memadr", 0, LW, 3'b010, 0, 0, ex(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
    step("lw_memrd",  0, LW, 3'b010, 0, 0, ex(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0));
    step("lw_memwb",  0, LW, 3'b010, 0, 0, ex(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1,0));

    // Reset held 2 cycles starting in MEMREAD aborts the load.
    step("rs_fetch",  0, LW, 3'b010, 0, 0, ex_fetch(2'b00));
    step("rs_decode", 0, LW, 3'b010, 0, 0, ex_decode(2'b00, 0));
    step("rs_memadr", 0, LW, 3'b010, 0, 0, ex(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
    step("rs_memrd",  1, LW, 3'b010, 0, 0, ex(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0));
    step("rs_held",   1, LW, 3'b010, 0, 0, ex_fetch(2'b00));
    step("rs_after",  0, SW, 3'b010, 0, 0, ex_fetch(2'b01));

    // sw: 4 cycles (FETCH above is cycle 1)
    step("sw_decode", 0, SW, 3'b010, 0, 0, ex_decode(2'b01, 0));
    step("sw_memadr", 0, SW, 3'b010, 0, 0, ex(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0));
    step("sw_memwr",  0, SW, 3'b010, 0, 0, ex(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));

    // R-type sub
    step("sub_fetch", 0, RT, 3'b000, 1, 0, ex_fetch(2'b00));
    step("sub_dec",   0, RT, 3'b000, 1, 0, ex_decode(2'b00, 0));
    step("sub_exec",  0, RT, 3'b000, 1, 0, ex(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0,0));
    step("sub_wb",    0, RT, 3'b000, 1, 0, ex_aluwb(2'b00));

    // addi with funct7b5=1 must stay add
    step("addi_fetch", 0, IA, 3'b000, 1, 0, ex_fetch(2'b00));
    step("addi_dec",   0, IA, 3'b000, 1, 0, ex_decode(2'b00, 0));
    step("addi_exec",  0, IA, 3'b000, 1, 0, ex(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
    step("addi_wb",    0, IA, 3'b000, 1, 0, ex_aluwb(2'b00));

    // R-type slt, or, and
    step("slt_fetch", 0, RT, 3'b010, 0, 0, ex_fetch(2'b00));
    step("slt_dec",   0, RT, 3'b010, 0, 0, ex_decode(2'b00, 0));
    step("slt_exec",  0, RT, 3'b010, 0, 0, ex(0,0,0,0,2'b00,2'b10,2'b00,3'b101,2'b00,0,0));
    step("slt_wb",    0, RT, 3'b010, 0, 0, ex_aluwb(2'b00));
    step("or_fetch",  0, RT, 3'b110, 0, 0, ex_fetch(2'b00));
    step("or_dec",    0, RT, 3'b110, 0, 0, ex_decode(2'b00, 0));
    step("or_exec",   0, RT, 3'b110, 0, 0, ex(0,0,0,0,2'b00,2'b10,2'b00,3'b011,2'b00,0,0));
    step("or_wb",     0, RT, 3'b110, 0, 0, ex_aluwb(2'b00));
    step("andi_fetch", 0, IA, 3'b111, 0, 0, ex_fetch(2'b00));
    step("andi_dec",   0, IA, 3'b111, 0, 0, ex_decode(2'b00, 0));
    step("andi_exec",  0, IA, 3'b111, 0, 0, ex(0,0,0,0,2'b00,2'b10,2'b01,3'b010,2'b00,0,0));
    step("andi_wb",    0, IA, 3'b111, 0, 0, ex_aluwb(2'b00));

    // beq taken, with Zero high in DECODE too (must not leak into PCWrite)
    step("beqt_fetch", 0, BQ, 3'b000, 0, 1, ex_fetch(2'b10));
    step("beqt_dec",   0, BQ, 3'b000, 0, 1, ex_decode(2'b10, 0));
    step("beqt_beq",   0, BQ, 3'b000, 0, 1, ex(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0));
    // beq not taken
    step("beqn_fetch", 0, BQ, 3'b000, 0, 0, ex_fetch(2'b10));
    step("beqn_dec",   0, BQ, 3'b000, 0, 0, ex_decode(2'b10, 0));
    step("beqn_beq",   0, BQ, 3'b000, 0, 0, ex(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0));

    // jal
    step("jal_fetch", 0, JL, 3'b000, 0, 0, ex_fetch(2'b11));
    step("jal_dec",   0, JL, 3'b000, 0, 0, ex_decode(2'b11, 0));
    step("jal_jal",   0, JL, 3'b000, 0, 0, ex(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,0));
    step("jal_wb",    0, JL, 3'b000, 0, 0, ex_aluwb(2'b11));

    // unsupported opcode: 2 cycles, illegal_op only in DECODE
    step("ill_fetch", 0, 7'b0000000, 3'b000, 0, 0, ex_fetch(2'b00));
    step("ill_dec",   0, 7'b0000000, 3'b000, 0, 0, ex_decode(2'b00, 1));
    step("ill_next",  0, 7'b0000000, 3'b000, 0, 0, ex_fetch(2'b00));
    step("ill_dec2",  0, LW, 3'b000, 0, 0, ex_decode(2'b00, 0));

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries never checked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
